// File: rtl/tg_cfg_shadow.sv
// rtl/tg_cfg_shadow.sv - double-buffered timing-generator parameter stage
//
// Shadow bank of three 4-bit timing parameters, written by the control side
// and copied to the active outputs only at a generator frame boundary, or by
// a watchdog when no frame boundary arrives in time.
//
// Optional feature macro: TG_CFG_RANGE_CHECK_EN (reject zero-valued writes).
//
// Parameters:
//   DEF1/DEF2/DEF3  reset/default values of B_test1/B_test2/B_test3
//   TIMEOUT_CYC     cycles spent waiting for frame_sync before a forced apply (>= 2)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  shadow write (addr 0..2 legal, 3 rejected)
//   commit              request shadow -> active transfer
//   frame_sync          frame boundary pulse from the timing generator
//   clr_sts             clear sticky cfg_tmo
//   B_test1..B_test3    active parameters
//   cfg_pend            transfer pending
//   cfg_upd             one-cycle pulse after active registers load
//   wr_nack             one-cycle pulse for a rejected write
//   cfg_tmo             sticky: an apply was forced by the watchdog
module tg_cfg_shadow #(
    parameter logic [3:0] DEF1        = 4'd5,
    parameter logic [3:0] DEF2        = 4'd7,
    parameter logic [3:0] DEF3        = 4'd9,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic       frame_sync,
    input  logic       clr_sts,
    output logic [3:0] B_test1,
    output logic [3:0] B_test2,
    output logic [3:0] B_test3,
    output logic       cfg_pend,
    output logic       cfg_upd,
    output logic       wr_nack,
    output logic       cfg_tmo
);

    localparam int            CW   = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [3:0] r_shd1, r_shd2, r_shd3;
    logic [3:0] r_act1, r_act2, r_act3;
    logic       r_upd, r_nack, r_tmo;

    logic w_data_ok;
    logic w_wr_accept;
    logic w_wr_reject;
    logic w_term;
    logic w_timeout;

`ifdef TG_CFG_RANGE_CHECK_EN
    // A zero-length timing field would stall the generator, so refuse it.
    assign w_data_ok = (wr_data != 4'd0);
`else
    assign w_data_ok = 1'b1;
`endif

    assign w_wr_accept = wr_en && (r_state == S_IDLE) && (wr_addr != 2'd3) && w_data_ok;
    assign w_wr_reject = wr_en && !w_wr_accept;
    assign w_term      = (r_cnt == TERM);
    // frame_sync on the terminal-count cycle is a normal apply, not a timeout.
    assign w_timeout   = (r_state == S_PEND) && !frame_sync && w_term;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (commit) begin
                    w_state_nxt = S_PEND;
                    w_cnt_nxt   = '0;
                end
            end
            S_PEND: begin
                if (frame_sync || w_term) begin
                    w_state_nxt = S_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            S_APPLY: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow bank: only IDLE writes land, so a commit's snapshot is frozen
    // from the commit edge onward (a same-cycle write is included).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd1 <= DEF1;
            r_shd2 <= DEF2;
            r_shd3 <= DEF3;
        end else if (w_wr_accept) begin
            case (wr_addr)
                2'd0:    r_shd1 <= wr_data;
                2'd1:    r_shd2 <= wr_data;
                2'd2:    r_shd3 <= wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act1 <= DEF1;
            r_act2 <= DEF2;
            r_act3 <= DEF3;
        end else if (r_state == S_APPLY) begin
            r_act1 <= r_shd1;
            r_act2 <= r_shd2;
            r_act3 <= r_shd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd  <= 1'b0;
            r_nack <= 1'b0;
            r_tmo  <= 1'b0;
        end else begin
            r_upd  <= (r_state == S_APPLY);
            r_nack <= w_wr_reject;
            // Set has priority over a same-cycle clear.
            if (w_timeout) begin
                r_tmo <= 1'b1;
            end else if (clr_sts) begin
                r_tmo <= 1'b0;
            end
        end
    end

    assign B_test1  = r_act1;
    assign B_test2  = r_act2;
    assign B_test3  = r_act3;
    assign cfg_pend = (r_state == S_PEND);
    assign cfg_upd  = r_upd;
    assign wr_nack  = r_nack;
    assign cfg_tmo  = r_tmo;

endmodule
